// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side drain stage: FSM encodings and
// default widths.
package fifo_rd_stream_pkg;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam int CNT_WIDTH_DEF = 16;
  localparam logic [1:0] BUF_FULL = 2'd2;

endpackage

// File: rtl/fifo_rd_stream_skid_buf.sv
// Two-entry output buffer: push at the tail, retire at the head, clear wins.
// Callers never push into a full buffer or retire from an empty one.
module rd_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            cnt,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] d0;
  logic [DATA_WIDTH-1:0] d1;

  assign head = d0;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 2'd0;
      d0  <= '0;
      d1  <= '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Simultaneous push and retire: occupancy unchanged, entries shift.
          if (cnt == 2'd1) begin
            d0 <= push_data;
          end else begin
            d0 <= d1;
            d1 <= push_data;
          end
        end
        2'b01: begin
          d0  <= d1;
          cnt <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) d0 <= push_data;
          else             d1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side drain stage: pops the read controller into a 2-entry buffer,
// streams it out as valid/ready, supports flushing and keeps pop/drop counts.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  // Stream handshake: a word moves when m_valid and m_ready are both high at
  // the rising edge; m_valid/m_data hold stable until that happens.
  logic [0:0] state;
  logic [1:0] cnt;
  logic       run;
  logic       pop;
  logic       xfer;
  logic       flush_start;

  assign run = (state == ST_RUN);

  // rinc sees only rempty and registered state, never m_ready.
  assign rinc        = ~r_rst & ~rempty & (~run | (cnt != BUF_FULL));
  assign pop         = rinc & ~rempty;
  assign m_valid     = run & (cnt != 2'd0);
  assign xfer        = m_valid & m_ready;
  assign flush_start = run & flush_req;
  assign flush_busy  = ~run;
  assign flush_done  = ~run & rempty;

  rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (r_clk),
    .rst      (r_rst),
    .clr      (flush_start),
    .push     (pop & run),
    .push_data(rdata),
    .pop      (xfer),
    .cnt      (cnt),
    .head     (m_data)
  );

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state      <= ST_RUN;
      pop_count  <= '0;
      drop_count <= '0;
    end else begin
      pop_count <= pop_count + CNT_WIDTH'(pop);
      if (flush_start) begin
        // Everything still buffered after this cycle's handshake is lost,
        // including a word popped in this same cycle.
        drop_count <= drop_count + CNT_WIDTH'(cnt) + CNT_WIDTH'(pop) - CNT_WIDTH'(xfer);
        state      <= ST_FLUSH;
      end else if (!run) begin
        drop_count <= drop_count + CNT_WIDTH'(pop);
        if (rempty) state <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a simple FWFT FIFO stand-in and an
// in-order scoreboard on the output stream.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       r_rst;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       flush_req;
  logic       flush_busy;
  logic       flush_done;
  logic [15:0] pop_count;
  logic [15:0] drop_count;

  logic       rst4;
  logic       rempty4;
  logic       rinc4;
  logic       m_valid4;
  logic [7:0] m_data4;
  logic       flush_busy4;
  logic       flush_done4;
  logic [3:0] pop_count4;
  logic [3:0] drop_count4;

  int n_tests = 0;
  int n_fail  = 0;
  int tb_pops = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // FIFO stand-in: first-word-fall-through, popped on rinc & ~rempty
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr % 64];

  always @(posedge clk) if (rinc && !rempty) rd_ptr <= rd_ptr + 1;

  fifo_rd_stream u_dut (
    .r_clk(clk), .r_rst(r_rst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .pop_count(pop_count), .drop_count(drop_count)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .r_clk(clk), .r_rst(rst4), .rempty(rempty4), .rdata(8'h77), .rinc(rinc4),
    .m_valid(m_valid4), .m_data(m_data4), .m_ready(1'b1),
    .flush_req(1'b0), .flush_busy(flush_busy4), .flush_done(flush_done4),
    .pop_count(pop_count4), .drop_count(drop_count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] w);
    mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic reset_dut();
    r_rst = 1'b1;
    tick();
    tick();
    r_rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard and pop monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!r_rst && rinc && !rempty) tb_pops++;
    if (!r_rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) check("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
      else check("beat", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int busy_n;
    int done_n;
    int bad_valid;
    int stable_bad;

    r_rst = 1'b1; m_ready = 1'b0; flush_req = 1'b0;
    rst4 = 1'b1; rempty4 = 1'b1;

    // Reset with 3 words waiting in the FIFO
    load(8'hA1); load(8'hA2); load(8'hA3);
    tick(); tick();
    check("rst_rinc", 32'(rinc), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(flush_busy), 32'd0);
    check("rst_done", 32'(flush_done), 32'd0);
    check("rst_pop_count", 32'(pop_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    r_rst = 1'b0;
    #1;
    check("rel_rinc", 32'(rinc), 32'd1);
    tick();
    check("first_valid", 32'(m_valid), 32'd1);
    check("first_data", 32'(m_data), 32'hA1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
    m_ready = 1'b1;
    wait_drain(20);
    tick();
    check("rst_test_pops", 32'(pop_count), 32'd3);

    // Streaming: 16 beats with no gaps
    reset_dut();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      load(8'(i));
      exp_q.push_back(8'(i));
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      if (m_valid !== 1'b1) check("stream_gap", 32'(m_valid), 32'd1);
    end
    tick();
    check("stream_done_valid", 32'(m_valid), 32'd0);
    check("stream_pops", 32'(pop_count), 32'd16);
    check("stream_left", 32'(exp_q.size()), 32'd0);

    // Back-pressure: 10 stalled cycles, then drain
    m_ready = 1'b0;
    reset_dut();
    tb_pops = 0;
    stable_bad = 0;
    for (int i = 1; i <= 16; i++) begin
      load(8'(i));
      exp_q.push_back(8'(i));
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid !== 1'b1 || m_data !== 8'h01) stable_bad++;
    end
    check("stall_pops", 32'(tb_pops), 32'd2);
    check("stall_hold", 32'(stable_bad), 32'd0);
    check("stall_rinc", 32'(rinc), 32'd0);
    m_ready = 1'b1;
    wait_drain(40);
    tick();
    check("bp_pops", 32'(pop_count), 32'd16);

    // Flush: 2 buffered + 5 in the FIFO, no downstream accept
    m_ready = 1'b0;
    reset_dut();
    for (int i = 0; i < 7; i++) load(8'(8'h31 + i));
    tick(); tick();
    check("pre_flush_data", 32'(m_data), 32'h31);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    busy_n = 0; done_n = 0; bad_valid = 0;
    for (int i = 0; i < 20 && flush_busy; i++) begin
      busy_n++;
      if (flush_done) done_n++;
      if (m_valid) bad_valid++;
      tick();
    end
    check("flush_busy_cycles", 32'(busy_n), 32'd6);
    check("flush_done_pulses", 32'(done_n), 32'd1);
    check("flush_valid", 32'(bad_valid), 32'd0);
    check("flush_drops", 32'(drop_count), 32'd7);
    check("flush_pops", 32'(pop_count), 32'd7);

    // Flush in the same cycle as the handshake of 0xAA with 2 buffered
    reset_dut();
    load(8'hAA); load(8'hBB);
    tick(); tick();
    exp_q.push_back(8'hAA);
    m_ready = 1'b1;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("hs_busy", 32'(flush_busy), 32'd1);
    check("hs_done_empty", 32'(flush_done), 32'd1);
    check("hs_valid", 32'(m_valid), 32'd0);
    check("hs_drops", 32'(drop_count), 32'd1);
    check("hs_pops", 32'(pop_count), 32'd2);
    tick();
    check("hs_back_run", 32'(flush_busy), 32'd0);
    check("hs_aa_seen", 32'(exp_q.size()), 32'd0);
    load(8'h5A);
    exp_q.push_back(8'h5A);
    wait_drain(10);

    // Counter wrap on a 4-bit instance: 17 pops
    rst4 = 1'b0;
    rempty4 = 1'b0;
    repeat (17) tick();
    rempty4 = 1'b1;
    tick();
    check("wrap_pops", 32'(pop_count4), 32'd1);
    check("wrap_drops", 32'(drop_count4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
